// File: rtl/alu_exec_pipe_if.sv
// Handshake and payload bundle between decode/control, the execute pipe and writeback.
// Signal names follow the block's external port list; clk/rst are kept outside.
interface alu_exec_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             invA;
  logic             invB;
  logic             Cin;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ofl;
  logic             zero;

  // Upstream/downstream side: drives operands, flush and out_ready.
  modport master (
    output flush, in_valid, A, B, invA, invB, Cin, op, out_ready,
    input  in_ready, out_valid, result, cout, ofl, zero
  );

  // Execute unit side.
  modport slave (
    input  flush, in_valid, A, B, invA, invB, Cin, op, out_ready,
    output in_ready, out_valid, result, cout, ofl, zero
  );
endinterface

// File: rtl/alu_exec_pipe.sv
// Two-stage elastic execute unit: S1 latches the conditioned operands, S2 holds the
// adder/logic result and flags. Valid/ready on both sides, synchronous flush.
module alu_exec_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_exec_pipe_if.slave    io_alu
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned SUM_W = WIDTH + 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_AND = 3'd1,
    OP_OR  = 3'd2,
    OP_XOR = 3'd3,
    OP_SEQ = 3'd4,
    OP_SLT = 3'd5,
    OP_SLE = 3'd6,
    OP_SCO = 3'd7
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] aop;
    logic [WIDTH-1:0] bop;
    logic             cin;
    op_e              op;
  } s1_t;

  logic             r_s1_valid;
  s1_t              r_s1;
  s1_t              w_s1_next;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ofl;
  logic             r_zero;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_xfer;

  logic [SUM_W-1:0] w_sum;
  logic             w_cout;
  logic             w_ofl;
  logic             w_eq;
  logic             w_lt;
  logic [WIDTH-1:0] w_result;
  logic             w_zero;

  // Elastic advance: in_ready depends on out_ready and stage occupancy only.
  assign w_s2_adv        = !r_out_valid || io_alu.out_ready;
  assign w_s1_adv        = !r_s1_valid || w_s2_adv;
  assign w_in_xfer       = io_alu.in_valid && w_s1_adv && !io_alu.flush;
  assign io_alu.in_ready = w_s1_adv;

  always_comb begin
    w_s1_next     = '0;
    w_s1_next.aop = io_alu.invA ? ~io_alu.A : io_alu.A;
    w_s1_next.bop = io_alu.invB ? ~io_alu.B : io_alu.B;
    w_s1_next.cin = io_alu.Cin;
    w_s1_next.op  = op_e'(io_alu.op);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (io_alu.flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= io_alu.in_valid;
    end
  end

  // Payload carries no reset; its valid bit gates every use.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_s1 <= w_s1_next;
    end
  end

  // Shared adder feeds ADD, the compares and the cout/ofl flags for every op.
  always_comb begin
    w_sum    = {1'b0, r_s1.aop} + {1'b0, r_s1.bop} + SUM_W'(r_s1.cin);
    w_cout   = w_sum[WIDTH];
    w_ofl    = (r_s1.aop[MSB] == r_s1.bop[MSB]) && (w_sum[MSB] != r_s1.aop[MSB]);
    w_eq     = (w_sum[MSB:0] == '0);
    w_lt     = w_sum[MSB] ^ w_ofl;
    w_result = '0;
    unique case (r_s1.op)
      OP_ADD:  w_result = w_sum[MSB:0];
      OP_AND:  w_result = r_s1.aop & r_s1.bop;
      OP_OR:   w_result = r_s1.aop | r_s1.bop;
      OP_XOR:  w_result = r_s1.aop ^ r_s1.bop;
      OP_SEQ:  w_result = WIDTH'(w_eq);
      OP_SLT:  w_result = WIDTH'(w_lt);
      OP_SLE:  w_result = WIDTH'(w_lt | w_eq);
      OP_SCO:  w_result = WIDTH'(w_cout);
      default: w_result = '0;
    endcase
    w_zero   = (w_result == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_ofl       <= 1'b0;
      r_zero      <= 1'b1;
    end else if (io_alu.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_result;
        r_cout   <= w_cout;
        r_ofl    <= w_ofl;
        r_zero   <= w_zero;
      end
    end
  end

  assign io_alu.out_valid = r_out_valid;
  assign io_alu.result    = r_result;
  assign io_alu.cout      = r_cout;
  assign io_alu.ofl       = r_ofl;
  assign io_alu.zero      = r_zero;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe: vector table through a scoreboard queue, plus
// backpressure, flush and asynchronous-reset sequences.
module tb_alu_exec_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NVEC  = 22;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        inva;
    logic        invb;
    logic        cin;
    logic [2:0]  op;
    logic [15:0] res;
    logic        cout;
    logic        ofl;
    logic        zero;
  } vec_t;

  logic clk;
  logic rst;
  logic bp_en;
  logic r_rand;
  logic ready_set;

  vec_t        vecs [NVEC];
  logic [18:0] q [$];
  logic [18:0] pending_exp;
  logic [18:0] prev_out;
  logic        prev_stall;
  int          n_cmp;
  int          n_err;
  int          n_out;

  alu_exec_pipe_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_pipe #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_alu (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.out_ready = bp_en ? r_rand : ready_set;

  always @(posedge clk) begin
    #1;
    r_rand = 1'($urandom_range(0, 1));
  end

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic inva,
                              input logic invb, input logic cin, input logic [2:0] op,
                              input logic [15:0] res, input logic cout, input logic ofl,
                              input logic zero);
    vec_t v;
    v.a = a; v.b = b; v.inva = inva; v.invb = invb; v.cin = cin; v.op = op;
    v.res = res; v.cout = cout; v.ofl = ofl; v.zero = zero;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: push on accepted input, pop and compare on output transfer.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
        check("stall_hold_data", 32'({bus.result, bus.cout, bus.ofl, bus.zero}), 32'(prev_out));
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got result 0x%0h with no bundle in flight at %0t",
                   bus.result, $time);
        end else begin
          check("result_flags", 32'({bus.result, bus.cout, bus.ofl, bus.zero}),
                32'(q.pop_front()));
        end
      end
      if (bus.flush) q.delete();
      else if (bus.in_valid && bus.in_ready) q.push_back(pending_exp);
      prev_stall = bus.out_valid && !bus.out_ready && !bus.flush;
      prev_out   = {bus.result, bus.cout, bus.ofl, bus.zero};
    end
  end

  task automatic set_vec(input int idx);
    bus.A       = vecs[idx].a;
    bus.B       = vecs[idx].b;
    bus.invA    = vecs[idx].inva;
    bus.invB    = vecs[idx].invb;
    bus.Cin     = vecs[idx].cin;
    bus.op      = vecs[idx].op;
    pending_exp = {vecs[idx].res, vecs[idx].cout, vecs[idx].ofl, vecs[idx].zero};
  endtask

  // Present one bundle; returns just after the accepting edge.
  task automatic send(input int idx);
    logic acc;
    set_vec(idx);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      acc = bus.in_ready && !bus.flush;
      @(posedge clk);
      #1;
      if (acc) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: vector %0d not accepted within 64 cycles", idx);
  endtask

  task automatic drain();
    for (int n = 0; n < 64; n++) begin
      if (q.size() == 0 && !bus.out_valid) return;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_err++;
    $display("FAIL drain_timeout: %0d results still pending after 64 cycles", q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int out0;
    n_cmp = 0; n_err = 0; n_out = 0;
    prev_stall = 1'b0; prev_out = '0; pending_exp = '0;
    r_rand = 1'b1; bp_en = 1'b0; ready_set = 1'b1;
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.A = '0; bus.B = '0; bus.invA = 1'b0; bus.invB = 1'b0; bus.Cin = 1'b0; bus.op = '0;

    //              A        B        iA iB ci op    result   co of z
    vecs[0]  = mk(16'h0003, 16'h0004, 0, 0, 0, 3'd0, 16'h0007, 0, 0, 0);
    vecs[1]  = mk(16'h0005, 16'h0003, 1, 0, 1, 3'd0, 16'hFFFE, 0, 0, 0);
    vecs[2]  = mk(16'h8000, 16'h7FFF, 1, 0, 1, 3'd0, 16'hFFFF, 0, 1, 0);
    vecs[3]  = mk(16'hFFFF, 16'h0001, 0, 1, 1, 3'd5, 16'h0001, 1, 0, 0);
    vecs[4]  = mk(16'h1234, 16'h1234, 0, 1, 1, 3'd4, 16'h0001, 1, 0, 0);
    vecs[5]  = mk(16'h7FFF, 16'h8000, 0, 1, 1, 3'd6, 16'h0000, 0, 1, 1);
    vecs[6]  = mk(16'hFFFF, 16'h0001, 0, 0, 0, 3'd7, 16'h0001, 1, 0, 0);
    vecs[7]  = mk(16'hF0F0, 16'hFF00, 0, 0, 0, 3'd1, 16'hF000, 1, 0, 0);
    vecs[8]  = mk(16'hF0F0, 16'hFF00, 0, 0, 0, 3'd2, 16'hFFF0, 1, 0, 0);
    vecs[9]  = mk(16'hF0F0, 16'hFF00, 0, 0, 0, 3'd3, 16'h0FF0, 1, 0, 0);
    vecs[10] = mk(16'hF0F0, 16'hFF00, 1, 0, 0, 3'd1, 16'h0F00, 1, 0, 0);
    vecs[11] = mk(16'hFFFF, 16'h0001, 0, 0, 0, 3'd0, 16'h0000, 1, 0, 1);
    vecs[12] = mk(16'h7FFF, 16'h0001, 0, 0, 0, 3'd0, 16'h8000, 0, 1, 0);
    vecs[13] = mk(16'h5555, 16'h5555, 0, 0, 0, 3'd3, 16'h0000, 0, 1, 1);
    vecs[14] = mk(16'h0001, 16'hFFFF, 0, 1, 1, 3'd5, 16'h0000, 0, 0, 1);
    vecs[15] = mk(16'h8000, 16'h8000, 0, 1, 1, 3'd6, 16'h0001, 1, 0, 0);
    vecs[16] = mk(16'h0001, 16'h0001, 0, 0, 0, 3'd0, 16'h0002, 0, 0, 0);
    vecs[17] = mk(16'h0010, 16'h0020, 0, 0, 0, 3'd0, 16'h0030, 0, 0, 0);
    vecs[18] = mk(16'h0100, 16'h0200, 0, 0, 0, 3'd0, 16'h0300, 0, 0, 0);
    vecs[19] = mk(16'hFFFF, 16'hFFFF, 0, 0, 0, 3'd0, 16'hFFFE, 1, 0, 0);
    vecs[20] = mk(16'h8000, 16'h0001, 0, 1, 1, 3'd5, 16'h0001, 1, 1, 0);
    vecs[21] = mk(16'h0001, 16'h0001, 0, 0, 0, 3'd7, 16'h0000, 0, 0, 1);

    // Reset values
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'({bus.cout, bus.ofl, bus.zero}), 32'b001);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Two-cycle latency on a single ADD
    send(0);
    check("lat_cycle1_idle", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
    check("lat_result", 32'(bus.result), 32'h0007);
    drain();

    // Full table back-to-back, then again under random backpressure
    for (int i = 1; i < NVEC; i++) begin
      if (i < 16 || i > 19) send(i);
    end
    drain();
    bp_en = 1'b1;
    for (int i = 0; i < 16; i++) send(i);
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    drain();

    // Backpressure: two accepted then in_ready drops; four results in order
    ready_set = 1'b0;
    send(16);
    send(17);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    out0 = n_out;
    ready_set = 1'b1;
    send(18);
    send(19);
    drain();
    check("bp_result_count", 32'(n_out - out0), 32'd4);

    // Flush with both stages full and a bundle presented
    ready_set = 1'b0;
    send(0);
    send(1);
    set_vec(2);
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    ready_set = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("flush_no_stale", 32'(bus.out_valid), 32'd0);
    end
    send(3);
    check("flush_lat_cycle1", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("flush_lat_cycle2", 32'(bus.out_valid), 32'd1);
    drain();

    // Flush beats a same-cycle accepted input
    send(4);
    set_vec(5);
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) begin
      check("flush_wins", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset between edges
    send(7);
    send(8);
    send(9);
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_zero", 32'(bus.zero), 32'd1);
    check("async_rst_result", 32'(bus.result), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
      check("rel_no_stale", 32'(bus.out_valid), 32'd0);
    end
    send(6);
    drain();
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
